rob_commit_ctrl: RTL and testbench
==================================

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, SHALL set the architectural register address width.
REQ-002 Parameter Q_WIDTH, default 4, SHALL set the tag width; usable tags are 1..2**Q_WIDTH-1 (15 entries), and tag 0 means "no producer".
REQ-003 Ports SHALL be, one per line, as name direction width meaning:
- clk_in  in  1  system clock; all state changes on its rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  when 0, all state holds and rd_control and has_commit are 0.
- control_hazard  in  1  flush of all in-flight entries.
- issue_valid  in  1  issue request.
- issue_rd  in  REG_ADDR_WIDTH  destination register of the request.
- issue_ready  out  1  entry available, i.e. count < 15.
- rd_control  out  1  issue accepted this cycle (to regfile).
- rd  out  REG_ADDR_WIDTH  equals issue_rd.
- Q_value  out  Q_WIDTH  tag allocated to the issue; always equals the tail tag.
- wb_valid  in  1  result writeback strobe.
- wb_tag  in  Q_WIDTH  tag of the result.
- wb_value  in  32  result value.
- has_commit  out  1  head entry retires this cycle.
- commit_target  out  REG_ADDR_WIDTH  destination register of the head entry.
- Commit_Q  out  Q_WIDTH  tag of the head entry.
- Commit_V  out  32  value of the head entry.
- rob_count  out  Q_WIDTH  number of allocated entries.

Function
REQ-004 Storage SHALL hold a circular buffer indexed by tag 1..15, with per-entry fields valid, ready, rd and value; head and tail SHALL be tag registers, and count SHALL be a 4-bit register.
REQ-005 Tag increment SHALL wrap from 15 to 1 and never produce 0.
REQ-006 rd_control SHALL be issue_valid && issue_ready && rdy_in && !control_hazard, combinationally.
REQ-007 On rd_control, at the clock edge the entry at tail SHALL become valid=1, ready=0, rd=issue_rd, and tail SHALL advance.
REQ-008 Issue to rd=0 SHALL still allocate an entry; suppressing the regfile write is the regfile's responsibility.
REQ-009 Each cycle with rdy_in=1 and !control_hazard, when wb_valid=1, wb_tag!=0 and entry[wb_tag].valid=1, the edge SHALL set ready=1 and value=wb_value.
REQ-010 A writeback to tag 0 or to an unallocated entry SHALL be ignored.
REQ-011 A repeat writeback to an entry SHALL overwrite its value.
REQ-012 has_commit SHALL be combinational: rdy_in && !control_hazard && count!=0 && entry[head].ready.
REQ-013 commit_target, Commit_Q and Commit_V SHALL show the head entry's rd, head and value at all times; they are don't-care when has_commit=0.
REQ-014 On has_commit, the edge SHALL clear entry[head].valid and entry[head].ready and advance head; at most one commit per cycle.
REQ-015 A writeback to the head tag SHALL make it committable in the following cycle, not the same cycle (ready is registered).
REQ-016 Simultaneous issue and commit SHALL leave count unchanged; issue alone SHALL increment count; commit alone SHALL decrement it.
REQ-017 When full (count=15), issue_ready SHALL be 0 even if a commit occurs that cycle; the freed slot SHALL be usable from the next cycle.
REQ-018 When control_hazard=1 with rdy_in=1, the edge SHALL clear all valid and ready bits, set head=tail=1 and count=0, and ignore that cycle's issue and writeback.
REQ-019 When rdy_in=0, all registers SHALL hold, including across control_hazard and wb_valid.

Reset
REQ-020 When rst_in=1 at an edge, regardless of rdy_in, the block SHALL set head=tail=1, count=0, and all valid, ready, rd and value fields to 0.
REQ-021 During and after reset, the block SHALL drive issue_ready=1, rd_control=0, has_commit=0, Q_value=1, Commit_Q=1 and rob_count=0.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight entries; no commit SHALL occur in the reset cycle.

Verification
REQ-023 Basic retire: after reset, issue rd=5 -> Q_value=1, rob_count=1; wb tag1 value 0xDEADBEEF -> next cycle has_commit=1, commit_target=5, Commit_Q=1, Commit_V=0xDEADBEEF; following cycle rob_count=0.
REQ-024 In-order commit: issue tags 1,2,3, then writeback order 3,1,2 -> commits occur in tag order 1,2,3 on three consecutive cycles, with no commit while tag1 is not ready.
REQ-025 Full and wrap: issue 15 entries -> issue_ready=0 and tail=1; commit one entry with issue_valid held -> no issue that cycle, issue accepted with Q_value=1 the next cycle.
REQ-026 Flush: 4 entries in flight with tag2 ready; assert control_hazard for one cycle alongside wb tag3 -> no commit, rob_count=0, next issue gets Q_value=1, and a late wb to tag3 is ignored.
REQ-027 Stall and stray writeback: hold rdy_in=0 with issue_valid=1 and wb_valid=1 -> rd_control=0, has_commit=0, no state change; wb to tag 0 or to an unallocated tag -> no entry becomes ready.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// In-order reorder buffer commit controller: allocates tags 1..2**Q_WIDTH-1 on issue,
// collects writebacks by tag, and retires the head entry once its result has arrived.
module rob_commit_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int Q_WIDTH        = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      control_hazard,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    output logic                      rd_control,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [Q_WIDTH-1:0]        Q_value,
    input  logic                      wb_valid,
    input  logic [Q_WIDTH-1:0]        wb_tag,
    input  logic [31:0]               wb_value,
    output logic                      has_commit,
    output logic [REG_ADDR_WIDTH-1:0] commit_target,
    output logic [Q_WIDTH-1:0]        Commit_Q,
    output logic [31:0]               Commit_V,
    output logic [Q_WIDTH-1:0]        rob_count
);

    localparam int                 DEPTH   = 2 ** Q_WIDTH;
    localparam logic [Q_WIDTH-1:0] TAG_ONE = {{(Q_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [Q_WIDTH-1:0] TAG_MAX = '1;

    logic                      entry_valid [DEPTH];
    logic                      entry_ready [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] entry_rd    [DEPTH];
    logic [31:0]               entry_value [DEPTH];

    logic [Q_WIDTH-1:0] head;
    logic [Q_WIDTH-1:0] tail;
    logic [Q_WIDTH-1:0] count;
    logic               active;
    logic               wb_hit;

    // Tag 0 is reserved for "no producer", so the pointers skip it on wrap.
    function automatic logic [Q_WIDTH-1:0] tag_inc(input logic [Q_WIDTH-1:0] t);
        return (t == TAG_MAX) ? TAG_ONE : t + TAG_ONE;
    endfunction

    // Outputs are forced to their reset values while rst_in is high so the
    // pre-reset unknown state never leaks out.
    always_comb begin
        active        = rdy_in && !control_hazard && !rst_in;
        issue_ready   = rst_in || (count != TAG_MAX);
        rd_control    = issue_valid && issue_ready && active;
        rd            = issue_rd;
        Q_value       = rst_in ? TAG_ONE : tail;
        has_commit    = active && (count != '0) && entry_ready[head];
        commit_target = entry_rd[head];
        Commit_Q      = rst_in ? TAG_ONE : head;
        Commit_V      = entry_value[head];
        rob_count     = rst_in ? '0 : count;
        wb_hit        = active && wb_valid && (wb_tag != '0) && entry_valid[wb_tag];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= TAG_ONE;
            tail  <= TAG_ONE;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_valid[i] <= 1'b0;
                entry_ready[i] <= 1'b0;
                entry_rd[i]    <= '0;
                entry_value[i] <= '0;
            end
        end else if (rdy_in) begin
            if (control_hazard) begin
                head  <= TAG_ONE;
                tail  <= TAG_ONE;
                count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    entry_valid[i] <= 1'b0;
                    entry_ready[i] <= 1'b0;
                end
            end else begin
                if (rd_control) begin
                    entry_valid[tail] <= 1'b1;
                    entry_ready[tail] <= 1'b0;
                    entry_rd[tail]    <= issue_rd;
                    tail              <= tag_inc(tail);
                end
                if (wb_hit) begin
                    entry_ready[wb_tag] <= 1'b1;
                    entry_value[wb_tag] <= wb_value;
                end
                // Placed after the writeback so a late result to the retiring head cannot revive it.
                if (has_commit) begin
                    entry_valid[head] <= 1'b0;
                    entry_ready[head] <= 1'b0;
                    head              <= tag_inc(head);
                end
                case ({rd_control, has_commit})
                    2'b10:   count <= count + TAG_ONE;
                    2'b01:   count <= count - TAG_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Randomized bench for rob_commit_ctrl against a queue-based in-order retirement model.
module tb_rob_commit_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, control_hazard, issue_valid, wb_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value;
    logic        issue_ready, rd_control, has_commit;
    logic [4:0]  rd, commit_target;
    logic [3:0]  Q_value, Commit_Q, rob_count;
    logic [31:0] Commit_V;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    rob_commit_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .control_hazard(control_hazard),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rd_control(rd_control), .rd(rd), .Q_value(Q_value),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .has_commit(has_commit), .commit_target(commit_target), .Commit_Q(Commit_Q),
        .Commit_V(Commit_V), .rob_count(rob_count)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] val;
    } ent_t;

    ent_t       q[$];
    logic [3:0] next_tag = 4'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, compare outputs against the model, then advance the model.
    task automatic step(input bit rst, input bit rdy, input bit haz, input bit iv,
                        input logic [4:0] ird, input bit wv, input logic [3:0] wt,
                        input logic [31:0] wval);
        bit         e_ready, e_issue, e_commit;
        logic [3:0] e_head;
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy; control_hazard = haz; issue_valid = iv;
        issue_rd = ird; wb_valid = wv; wb_tag = wt; wb_value = wval;
        #1;
        e_ready  = rst || (q.size() < 15);
        e_issue  = !rst && rdy && !haz && iv && e_ready;
        e_commit = !rst && rdy && !haz && (q.size() > 0) && q[0].done;
        e_head   = rst ? 4'd1 : ((q.size() > 0) ? q[0].tag : next_tag);
        chk("issue_ready", 32'(issue_ready), 32'(e_ready));
        chk("rd_control",  32'(rd_control),  32'(e_issue));
        chk("rd",          32'(rd),          32'(ird));
        chk("Q_value",     32'(Q_value),     32'(rst ? 4'd1 : next_tag));
        chk("has_commit",  32'(has_commit),  32'(e_commit));
        chk("Commit_Q",    32'(Commit_Q),    32'(e_head));
        chk("rob_count",   32'(rob_count),   32'(rst ? 0 : q.size()));
        if (e_commit) begin
            chk("commit_target", 32'(commit_target), 32'(q[0].rd));
            chk("Commit_V",      Commit_V,           q[0].val);
        end
        if (rst || (rdy && haz)) begin
            q.delete();
            next_tag = 4'd1;
        end else if (rdy) begin
            if (wv)
                foreach (q[i])
                    if (q[i].tag == wt) begin
                        q[i].done = 1'b1;
                        q[i].val  = wval;
                    end
            if (e_commit) void'(q.pop_front());
            if (e_issue) begin
                q.push_back('{tag: next_tag, rd: ird, done: 1'b0, val: 32'd0});
                next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
            end
        end
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 5'd0, 0, 4'd0, 32'd0);
    endtask

    task automatic issue(input logic [4:0] r);
        step(0, 1, 0, 1, r, 0, 4'd0, 32'd0);
    endtask

    task automatic wb(input logic [3:0] t, input logic [31:0] v);
        step(0, 1, 0, 0, 5'd0, 1, t, v);
    endtask

    task automatic reset();
        step(1, $urandom_range(1), 0, 1, 5'd3, 0, 4'd0, 32'd0);
        step(1, 1, 0, 0, 5'd0, 0, 4'd0, 32'd0);
    endtask

    initial begin
        reset();

        // Basic retire
        issue(5'd5);
        wb(4'd1, 32'hDEADBEEF);
        idle();
        idle();

        // In-order commit with out-of-order writeback
        issue(5'd1); issue(5'd2); issue(5'd3);
        wb(4'd3, 32'h33); wb(4'd1, 32'h11); wb(4'd2, 32'h22);
        repeat (4) idle();

        // Full and wrap
        reset();
        for (int i = 0; i < 15; i++) issue(5'(i + 1));
        step(0, 1, 0, 1, 5'd9, 1, 4'd1, 32'hAAAA0001);
        step(0, 1, 0, 1, 5'd9, 0, 4'd0, 32'd0);
        step(0, 1, 0, 1, 5'd10, 0, 4'd0, 32'd0);
        step(0, 1, 0, 1, 5'd11, 0, 4'd0, 32'd0);

        // Flush with a writeback in the same cycle, then a late writeback
        reset();
        for (int i = 0; i < 4; i++) issue(5'(i + 7));
        wb(4'd2, 32'h2222);
        step(0, 1, 1, 1, 5'd4, 1, 4'd3, 32'h3333);
        issue(5'd12);
        wb(4'd3, 32'h3333);
        repeat (2) idle();

        // Stall and stray writebacks
        reset();
        issue(5'd6); issue(5'd7);
        step(0, 0, 0, 1, 5'd8, 1, 4'd1, 32'h5555);
        step(0, 0, 1, 1, 5'd8, 1, 4'd2, 32'h6666);
        wb(4'd0, 32'h7777);
        wb(4'd9, 32'h8888);
        repeat (2) idle();
        wb(4'd2, 32'h9999);
        wb(4'd1, 32'hABCD);
        repeat (3) idle();

        // Randomized phases with varying writeback pressure
        for (int ph = 0; ph < 12; ph++) begin
            int wb_pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 85);
            for (int c = 0; c < 250; c++) begin
                bit         r_rst = ($urandom_range(399) == 0);
                bit         r_rdy = ($urandom_range(99) < 88);
                bit         r_haz = ($urandom_range(99) < 2);
                bit         r_iv  = ($urandom_range(99) < 70);
                bit         r_wv  = ($urandom_range(99) < wb_pct);
                logic [3:0] r_wt;
                if (q.size() > 0 && $urandom_range(3) != 0)
                    r_wt = q[$urandom_range(q.size() - 1)].tag;
                else
                    r_wt = 4'($urandom_range(15));
                step(r_rst, r_rdy, r_haz, r_iv, 5'($urandom), r_wv, r_wt, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
